// File: rtl/hand_allocator_pkg.sv
// Shared pool geometry, FSM encoding and the popcount helper used by the
// hand_allocator block and its bitmap.
package hand_alloc_defs;

    localparam int NUM_BLOCKS  = 16;
    localparam int BLOCK_WORDS = 64;
    localparam int ADDR_W      = 10;
    localparam int IDX_W       = 4;
    localparam int OFS_W       = 6;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FOUND = 2'd2,
        FAIL  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_BLOCKS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/hand_allocator_if.sv
// Allocate/release handshake between a requester (master) and the allocator (slave).
interface hand_allocator_if
    import hand_alloc_defs::*;
();
    logic              enable;
    logic              adr_found;
    logic [ADDR_W-1:0] address;
    logic              pool_full;
    logic              free_enable;
    logic [ADDR_W-1:0] free_address;
    logic              free_ack;
    logic              free_err;
    logic [CNT_W-1:0]  used_count;

    modport master (
        output enable, free_enable, free_address,
        input  adr_found, address, pool_full, free_ack, free_err, used_count
    );

    modport slave (
        input  enable, free_enable, free_address,
        output adr_found, address, pool_full, free_ack, free_err, used_count
    );
endinterface

// File: rtl/hand_allocator_block_bitmap.sv
// Per-block used bitmap with one set port, one clear port, two read-by-index
// ports (scan and free check) and a live popcount.
module block_bitmap
    import hand_alloc_defs::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] scan_idx,
    output logic             scan_bit,
    input  logic [IDX_W-1:0] free_idx,
    output logic             free_bit,
    output logic [CNT_W-1:0] count
);
    logic [NUM_BLOCKS-1:0] used, used_nxt;

    // Set and clear never target the same block: a scan treats a block being freed as used.
    always_comb begin
        used_nxt = used;
        if (set_en) used_nxt[set_idx] = 1'b1;
        if (clr_en) used_nxt[clr_idx] = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) used <= '0;
        else         used <= used_nxt;
    end

    assign scan_bit = used[scan_idx];
    assign free_bit = used[free_idx];
    assign count    = popcount(used);
endmodule

// File: rtl/hand_allocator.sv
// Fixed-block allocator: round-robin scan of a 16 x 64-word pool with
// level-held grant/full handshake and single-cycle release acknowledgement.
module hand_allocator
    import hand_alloc_defs::*;
(
    input  logic              clock,
    input  logic              resetn,
    hand_allocator_if.slave   bus
);
    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt, next_ptr, next_ptr_nxt, cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              set_en, scan_bit, free_bit, free_ok, ack_q, err_q;
    logic [IDX_W-1:0]  free_idx;

    assign free_idx = bus.free_address[ADDR_W-1:OFS_W];
    assign free_ok  = bus.free_enable && (bus.free_address[OFS_W-1:0] == '0) && free_bit;

    block_bitmap u_bitmap (
        .clock    (clock),
        .resetn   (resetn),
        .set_en   (set_en),
        .set_idx  (ptr),
        .clr_en   (free_ok),
        .clr_idx  (free_idx),
        .scan_idx (ptr),
        .scan_bit (scan_bit),
        .free_idx (free_idx),
        .free_bit (free_bit),
        .count    (bus.used_count)
    );

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        next_ptr_nxt = next_ptr;
        addr_nxt     = addr_q;
        set_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt = SCAN;
                    ptr_nxt   = next_ptr;
                    cnt_nxt   = '0;
                end
            end
            SCAN: begin
                // Dropping the request wins over a grant so an abandoned scan claims nothing.
                if (!bus.enable) begin
                    state_nxt = IDLE;
                end else if (!scan_bit) begin
                    set_en       = 1'b1;
                    addr_nxt     = {ptr, {OFS_W{1'b0}}};
                    next_ptr_nxt = ptr + 1'b1;
                    state_nxt    = FOUND;
                end else if (cnt == IDX_W'(NUM_BLOCKS - 1)) begin
                    state_nxt = FAIL;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FOUND, FAIL: begin
                if (!bus.enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            next_ptr <= '0;
            addr_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            next_ptr <= next_ptr_nxt;
            addr_q   <= addr_nxt;
            ack_q    <= free_ok;
            err_q    <= bus.free_enable && !free_ok;
        end
    end

    assign bus.adr_found = (state == FOUND);
    assign bus.pool_full = (state == FAIL);
    assign bus.address   = addr_q;
    assign bus.free_ack  = ack_q;
    assign bus.free_err  = err_q;
endmodule

// File: doc/hand_allocator.md
HAND_ALLOCATOR -- requirements
Module: hand_allocator

Interface
REQ-001 clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 resetn  input  1  reset, asynchronous and active-low.
REQ-003 enable  input  1  allocation request, level; requester holds high until adr_found, then drops it.
REQ-004 adr_found  output  1  allocation granted; held high with address until enable is sampled low.
REQ-005 address  output  10  base address of the granted block (block index * 64).
REQ-006 pool_full  output  1  allocation failed, all blocks used; held until enable is sampled low.
REQ-007 free_enable  input  1  single-cycle pulse requesting release of a block.
REQ-008 free_address  input  10  base address of the block to release; sampled with free_enable.
REQ-009 free_ack  output  1  one-cycle pulse: release accepted.
REQ-010 free_err  output  1  one-cycle pulse: release rejected (misaligned or block not in use).
REQ-011 used_count  output  5  number of blocks currently allocated, 0..16.

Function
REQ-012 Pool SHALL be 16 blocks x 64 words covering the 10-bit address space, tracked by a 16-bit used bitmap.
REQ-013 FSM states SHALL be IDLE, SCAN, FOUND, FAIL.
REQ-014 IDLE: enable sampled high -> SCAN, with scan pointer loaded from next_ptr and scan counter cleared.
REQ-015 SCAN: each cycle SHALL test one block (bitmap value before this edge). If free: set its bit, address <= ptr*64, next_ptr <= ptr+1 mod 16, go FOUND. If used: ptr <= ptr+1 mod 16, counter+1.
REQ-016 SCAN: after 16 used blocks are tested, go FAIL.
REQ-017 Latency: enable sampled at edge N gives adr_found high after edge N+1 (best case) or after edge N+16 (worst case). pool_full rises after edge N+16.
REQ-018 FOUND: adr_found=1 and address stable; enable sampled low -> IDLE, adr_found=0 after that edge.
REQ-019 FAIL: pool_full=1, adr_found=0; enable sampled low -> IDLE.
REQ-020 enable dropping during SCAN SHALL abort the scan at the next edge -> IDLE, with no bit set.
REQ-021 Free request, accepted in every state:
  - Condition: free_address[5:0]==0 and the block's bit is set.
  - Result: the bit is cleared at that edge and free_ack pulses high for the following cycle.
  - Otherwise: free_err pulses and the bitmap is unchanged.
REQ-022 A free and a SCAN test of the same block in the same cycle SHALL resolve as follows: the scan sees the block as used, and the free clears it.
REQ-023 used_count SHALL equal the popcount of the bitmap. It is updated on the same edge as any set or clear, and a simultaneous set and clear leaves it unchanged.
REQ-024 next_ptr wraps from 15 to 0.

Reset
REQ-025 resetn low SHALL force these values immediately, including mid-scan:
  - state IDLE, bitmap 0, next_ptr 0;
  - adr_found, pool_full, free_ack, free_err 0;
  - address 0, used_count 0.
REQ-026 After reset release, the first allocation SHALL return address 0.

Structure
REQ-027 Shared header hand_alloc_defs SHALL hold NUM_BLOCKS=16, BLOCK_WORDS=64, ADDR_W=10, the FSM state encodings, and the 5-bit count width.
REQ-028 One sub-module, block_bitmap, SHALL hold the used bitmap, the set/clear ports, bit read-by-index, and the popcount. The FSM stays in hand_allocator.

Verification
REQ-029 Reset, enable held high -> adr_found high 2 edges later, address=0, used_count=1; drop enable -> adr_found low next cycle.
REQ-030 Four back-to-back handshakes -> addresses 0, 64, 128, 192; used_count=4.
REQ-031 Allocate all 16 blocks, then request a 17th -> pool_full rises after 16 scan cycles with adr_found=0; drop enable -> IDLE.
REQ-032 With the pool full:
  - free_address=320 -> free_ack pulse and used_count=15;
  - next request -> address=320;
  - free_address=321 or an unused block -> free_err pulse, with no change.
REQ-033 Assert resetn low mid-SCAN -> all outputs 0 immediately; the next request returns address 0.
REQ-034 With block 5 used and the scan pointer at 5, free block 5 in the same cycle -> scan skips block 5, free_ack pulses, and the grant is the next free block.
